// File: rtl/data_memory_banked.sv
// data_memory_banked: banked data memory for the MEM stage.
// Decodes up to four RAM regions plus one MMIO window, performs big-endian
// byte/half/word loads and stores, and answers each request with a one-cycle
// response strobe. Faults cover illegal size, misalignment, unmapped
// addresses and MMIO timeouts.
module data_memory_banked #(
  parameter int          NUM_REGIONS  = 2,
  parameter logic [15:0] REGION0_TAG  = 16'h1000,
  parameter logic [15:0] REGION1_TAG  = 16'h7fff,
  parameter logic [15:0] REGION2_TAG  = 16'h2000,
  parameter logic [15:0] REGION3_TAG  = 16'h3000,
  parameter int          WORDS_LOG2   = 10,
  parameter logic [15:0] MMIO_TAG     = 16'hffff,
  parameter int          MMIO_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_in,
  input  logic [31:0] addr_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic [31:0] writedata_in,
  output logic        ready_out,
  output logic        resp_valid_out,
  output logic [31:0] readdata_out,
  output logic        fault_out,
  output logic        mmio_req_out,
  output logic        mmio_we_out,
  output logic [3:0]  mmio_addr_out,
  output logic [31:0] mmio_wdata_out,
  input  logic        mmio_ack_in,
  input  logic [31:0] mmio_rdata_in
);

  localparam int          DEPTH        = 1 << WORDS_LOG2;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(MMIO_TIMEOUT - 1);
  localparam logic [15:0] REGION_TAGS [4] = '{REGION0_TAG, REGION1_TAG, REGION2_TAG, REGION3_TAG};

  typedef enum logic [1:0] {IDLE, MMIO_WAIT, MMIO_RESP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        accept;

  logic [15:0] tag;
  logic [3:0]  tag_match;
  logic        hit;
  logic [1:0]  hit_idx;
  logic        is_mmio;
  logic        misalign;
  logic        req_fault;
  logic        ram_en;
  logic [WORDS_LOG2-1:0] word_idx;
  logic [3:0]  byte_en;
  logic [31:0] wlanes;

  logic        resp_valid_reg, fault_reg, we_reg, signed_reg, src_mmio_reg;
  logic [1:0]  size_reg, off_reg, region_sel_reg;
  logic [3:0]  mmio_addr_reg;
  logic [31:0] mmio_wdata_reg, mmio_rdata_reg;
  logic [31:0] region_rdata [4];
  logic [31:0] ld_src, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_addr_bits;

  // Bits between the region word index and the tag only alias (regions wrap).
  assign unused_addr_bits = ^addr_in[15:WORDS_LOG2+2];

  assign tag      = addr_in[31:16];
  assign is_mmio  = (tag == MMIO_TAG);
  assign word_idx = addr_in[WORDS_LOG2+1:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_match
    if (gi < NUM_REGIONS) begin : g_on
      assign tag_match[gi] = (tag == REGION_TAGS[gi]);
    end else begin : g_off
      assign tag_match[gi] = 1'b0;
    end
  end

  // Lowest-numbered matching region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (tag_match[i]) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign misalign  = (size_in == 2'b10) ||
                     ((size_in == 2'b01) && addr_in[0]) ||
                     ((size_in == 2'b11) && (addr_in[1:0] != 2'b00));
  assign req_fault = misalign || (!is_mmio && !hit);
  assign ram_en    = accept && !is_mmio && !req_fault;

  // Big-endian lane enables and replicated store data (lane 3 = bits [31:24]).
  always_comb begin
    byte_en = 4'b1111;
    wlanes  = writedata_in;
    case (size_in)
      2'b00: begin
        byte_en = 4'b1000 >> addr_in[1:0];
        wlanes  = {4{writedata_in[7:0]}};
      end
      2'b01: begin
        byte_en = addr_in[1] ? 4'b0011 : 4'b1100;
        wlanes  = {2{writedata_in[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wlanes  = writedata_in;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_region
    if (gi < NUM_REGIONS) begin : g_ram
      logic [31:0] mem [DEPTH];
      logic [31:0] rdata_reg;
      // Lane-masked write and registered read of the selected region.
      always_ff @(posedge clock) begin
        if (ram_en && (hit_idx == 2'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (we_in && byte_en[b]) mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
          end
          rdata_reg <= mem[word_idx];
        end
      end
      assign region_rdata[gi] = rdata_reg;
    end else begin : g_empty
      assign region_rdata[gi] = 32'h0;
    end
  end

  // Next-state logic: IDLE and MMIO_RESP both accept new requests.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, MMIO_RESP: begin
        accept     = req_in;
        state_next = IDLE;
        if (req_in && is_mmio && !req_fault) begin
          state_next = MMIO_WAIT;
          cnt_next   = 8'd0;
        end
      end
      MMIO_WAIT: begin
        cnt_next = cnt_reg + 8'd1;
        if (mmio_ack_in || (cnt_reg == TIMEOUT_LAST)) state_next = MMIO_RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture request attributes and produce the one-cycle response strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
      we_reg         <= 1'b0;
      signed_reg     <= 1'b0;
      src_mmio_reg   <= 1'b0;
      size_reg       <= 2'b00;
      off_reg        <= 2'b00;
      region_sel_reg <= 2'b00;
      mmio_addr_reg  <= 4'h0;
      mmio_wdata_reg <= 32'h0;
      mmio_rdata_reg <= 32'h0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (accept) begin
        we_reg         <= we_in;
        size_reg       <= size_in;
        signed_reg     <= signed_in;
        off_reg        <= addr_in[1:0];
        region_sel_reg <= hit_idx;
        src_mmio_reg   <= is_mmio;
        fault_reg      <= req_fault;
        mmio_addr_reg  <= addr_in[3:0];
        mmio_wdata_reg <= writedata_in;
        resp_valid_reg <= !(is_mmio && !req_fault);
      end else if (state_reg == MMIO_WAIT) begin
        if (mmio_ack_in) begin
          resp_valid_reg <= 1'b1;
          mmio_rdata_reg <= mmio_rdata_in;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          resp_valid_reg <= 1'b1;
          fault_reg      <= 1'b1;
        end
      end
    end
  end

  // Right-justify the addressed lanes and apply zero/sign fill.
  always_comb begin
    ld_src  = src_mmio_reg ? mmio_rdata_reg : region_rdata[region_sel_reg];
    ld_byte = 8'h0;
    ld_half = 16'h0;
    ld_data = ld_src;
    case (size_reg)
      2'b00: begin
        case (off_reg)
          2'd0:    ld_byte = ld_src[31:24];
          2'd1:    ld_byte = ld_src[23:16];
          2'd2:    ld_byte = ld_src[15:8];
          default: ld_byte = ld_src[7:0];
        endcase
        ld_data = {{24{signed_reg & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        ld_half = off_reg[1] ? ld_src[15:0] : ld_src[31:16];
        ld_data = {{16{signed_reg & ld_half[15]}}, ld_half};
      end
      default: ld_data = ld_src;
    endcase
  end

  assign ready_out      = (state_reg != MMIO_WAIT);
  assign resp_valid_out = resp_valid_reg;
  assign fault_out      = resp_valid_reg & fault_reg;
  assign readdata_out   = (resp_valid_reg && !fault_reg && !we_reg) ? ld_data : 32'h0;
  assign mmio_req_out   = (state_reg == MMIO_WAIT);
  assign mmio_we_out    = mmio_req_out & we_reg;
  assign mmio_addr_out  = mmio_req_out ? mmio_addr_reg : 4'h0;
  assign mmio_wdata_out = mmio_req_out ? mmio_wdata_reg : 32'h0;

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed testbench for data_memory_banked: a pipelined table of RAM
// accesses followed by hand-written MMIO ack, timeout and reset sequences.
module tb_data_memory_banked;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_in = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic        we_in = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic        signed_in = 1'b0;
  logic [31:0] writedata_in = 32'h0;
  logic        ready_out, resp_valid_out, fault_out;
  logic [31:0] readdata_out;
  logic        mmio_req_out, mmio_we_out;
  logic [3:0]  mmio_addr_out;
  logic [31:0] mmio_wdata_out;
  logic        mmio_ack_in = 1'b0;
  logic [31:0] mmio_rdata_in = 32'h0;

  int checks = 0;
  int passed = 0;

  data_memory_banked #(
    .NUM_REGIONS(2), .WORDS_LOG2(10), .MMIO_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .req_in(req_in), .addr_in(addr_in),
    .we_in(we_in), .size_in(size_in), .signed_in(signed_in),
    .writedata_in(writedata_in), .ready_out(ready_out),
    .resp_valid_out(resp_valid_out), .readdata_out(readdata_out),
    .fault_out(fault_out), .mmio_req_out(mmio_req_out),
    .mmio_we_out(mmio_we_out), .mmio_addr_out(mmio_addr_out),
    .mmio_wdata_out(mmio_wdata_out), .mmio_ack_in(mmio_ack_in),
    .mmio_rdata_in(mmio_rdata_in)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic w, input logic [1:0] s,
                     input logic sg, input logic [31:0] wd,
                     input logic [31:0] rd, input logic f);
    vec_t v;
    v.addr = a; v.we = w; v.size = s; v.sgn = sg; v.wd = wd; v.exp_rd = rd; v.exp_f = f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    req_in = 1'b1; addr_in = v.addr; we_in = v.we; size_in = v.size;
    signed_in = v.sgn; writedata_in = v.wd;
  endtask

  task automatic idle_inputs();
    req_in = 1'b0; addr_in = 32'h0; we_in = 1'b0; size_in = 2'b00;
    signed_in = 1'b0; writedata_in = 32'h0;
  endtask

  // Checks the response for v in the cycle after its acceptance.
  task automatic chk_resp(input string tag, input vec_t v);
    chk({tag, " resp_valid"}, 32'(resp_valid_out), 32'd1);
    chk({tag, " fault"}, 32'(fault_out), 32'(v.exp_f));
    chk({tag, " readdata"}, readdata_out, v.exp_rd);
    chk({tag, " ready"}, 32'(ready_out), 32'd1);
    chk({tag, " mmio_req"}, 32'(mmio_req_out), 32'd0);
    $display("txn %s addr=%h we=%0d size=%0d sgn=%0d rd=%h fault=%0d",
             tag, v.addr, v.we, v.size, v.sgn, readdata_out, fault_out);
  endtask

  // Single non-pipelined access, starting from a point after a negedge.
  task automatic single(input string tag, input vec_t v);
    @(posedge clock); #1;
    drive(v);
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    chk_resp(tag, v);
  endtask

  initial begin
    vec_t v;
    int   hits;

    // Vectors applied back-to-back, one per cycle.
    add(32'h10000010, 1, 2'b11, 0, 32'hDEADBEEF, 32'h0,        0); // 0
    add(32'h10000010, 0, 2'b11, 0, 32'h0,        32'hDEADBEEF, 0); // 1 write-first
    add(32'h10000011, 0, 2'b00, 1, 32'h0,        32'hFFFFFFAD, 0); // 2
    add(32'h10000011, 0, 2'b00, 0, 32'h0,        32'h000000AD, 0); // 3
    add(32'h10000012, 1, 2'b01, 0, 32'h00001234, 32'h0,        0); // 4
    add(32'h10000010, 0, 2'b11, 0, 32'h0,        32'hDEAD1234, 0); // 5
    add(32'h10001000, 1, 2'b11, 0, 32'h00000011, 32'h0,        0); // 6 wraps to word 0
    add(32'h10000000, 0, 2'b11, 0, 32'h0,        32'h00000011, 0); // 7
    add(32'h10000ffc, 1, 2'b11, 0, 32'hA5A5A5A5, 32'h0,        0); // 8
    add(32'h7fff0ffc, 1, 2'b11, 0, 32'hCAFEF00D, 32'h0,        0); // 9
    add(32'h7fff0ffc, 0, 2'b11, 0, 32'h0,        32'hCAFEF00D, 0); // 10
    add(32'h10000ffc, 0, 2'b11, 0, 32'h0,        32'hA5A5A5A5, 0); // 11
    add(32'h20000000, 0, 2'b11, 0, 32'h0,        32'h0,        1); // 12 unmapped
    add(32'h10000002, 0, 2'b11, 0, 32'h0,        32'h0,        1); // 13 misaligned
    add(32'h10000002, 1, 2'b11, 0, 32'hFFFFFFFF, 32'h0,        1); // 14 faulting store
    add(32'h10000000, 0, 2'b11, 0, 32'h0,        32'h00000011, 0); // 15 untouched
    add(32'h10000010, 0, 2'b10, 0, 32'h0,        32'h0,        1); // 16 illegal size
    add(32'h10000011, 0, 2'b01, 0, 32'h0,        32'h0,        1); // 17 odd half
    add(32'h10000010, 0, 2'b01, 1, 32'h0,        32'hFFFFDEAD, 0); // 18
    add(32'h10000012, 0, 2'b01, 1, 32'h0,        32'h00001234, 0); // 19
    add(32'h10000013, 0, 2'b00, 1, 32'h0,        32'h00000034, 0); // 20
    add(32'h10000010, 0, 2'b00, 0, 32'h0,        32'h000000DE, 0); // 21
    add(32'h10000010, 1, 2'b00, 0, 32'hAABBCC77, 32'h0,        0); // 22
    add(32'h10000010, 0, 2'b11, 0, 32'h0,        32'h77AD1234, 0); // 23
    add(32'hffff0002, 0, 2'b11, 0, 32'h0,        32'h0,        1); // 24 MMIO misaligned
    add(32'h7fff1ffc, 0, 2'b11, 0, 32'h0,        32'hCAFEF00D, 0); // 25 stack wrap

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst resp_valid", 32'(resp_valid_out), 32'd0);
    chk("rst fault", 32'(fault_out), 32'd0);
    chk("rst readdata", readdata_out, 32'h0);
    chk("rst mmio_req", 32'(mmio_req_out), 32'd0);
    chk("rst mmio_addr", 32'(mmio_addr_out), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post-rst ready", 32'(ready_out), 32'd1);
    chk("post-rst resp_valid", 32'(resp_valid_out), 32'd0);

    // Pipelined table.
    @(posedge clock); #1;
    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock); #1;
      if (i + 1 < vecs.size()) drive(vecs[i + 1]);
      else idle_inputs();
      @(negedge clock);
      chk_resp($sformatf("vec%0d", i), vecs[i]);
    end
    @(negedge clock);
    chk("idle resp_valid", 32'(resp_valid_out), 32'd0);

    // MMIO word load, ack in the 4th wait cycle; a stray RAM store is offered
    // while busy and must be ignored.
    @(posedge clock); #1;
    v = '{32'hffff0004, 1'b0, 2'b11, 1'b0, 32'h0, 32'h00000041, 1'b0};
    drive(v);
    @(posedge clock); #1;
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("mmio ld c%0d req", c), 32'(mmio_req_out), 32'd1);
      chk($sformatf("mmio ld c%0d ready", c), 32'(ready_out), 32'd0);
      chk($sformatf("mmio ld c%0d addr", c), 32'(mmio_addr_out), 32'd4);
      chk($sformatf("mmio ld c%0d we", c), 32'(mmio_we_out), 32'd0);
      chk($sformatf("mmio ld c%0d resp_valid", c), 32'(resp_valid_out), 32'd0);
      if (c == 1) begin
        req_in = 1'b1; addr_in = 32'h10000010; we_in = 1'b1; size_in = 2'b11;
        writedata_in = 32'h0BADBAD0;
      end
      if (c == 4) begin
        idle_inputs();
        mmio_ack_in = 1'b1; mmio_rdata_in = 32'h00000041;
      end
    end
    @(posedge clock); #1;
    mmio_ack_in = 1'b0; mmio_rdata_in = 32'h0;
    @(negedge clock);
    chk_resp("mmio ld", v);
    v = '{32'h10000010, 1'b0, 2'b11, 1'b0, 32'h0, 32'h77AD1234, 1'b0};
    single("busy store ignored", v);

    // MMIO byte load with ack in the same cycle as the timeout: success.
    @(posedge clock); #1;
    v = '{32'hffff0000, 1'b0, 2'b00, 1'b1, 32'h0, 32'hFFFFFF80, 1'b0};
    drive(v);
    @(posedge clock); #1;
    idle_inputs();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      chk($sformatf("mmio edge c%0d req", c), 32'(mmio_req_out), 32'd1);
      if (c == 8) begin
        mmio_ack_in = 1'b1; mmio_rdata_in = 32'h80000000;
      end
    end
    @(posedge clock); #1;
    mmio_ack_in = 1'b0; mmio_rdata_in = 32'h0;
    @(negedge clock);
    chk_resp("mmio ack at timeout", v);

    // MMIO store with no ack: 8 cycles of request, then fault response.
    @(posedge clock); #1;
    v = '{32'hffff0008, 1'b1, 2'b11, 1'b0, 32'h00000055, 32'h0, 1'b1};
    drive(v);
    @(posedge clock); #1;
    idle_inputs();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      chk($sformatf("mmio to c%0d req", c), 32'(mmio_req_out), 32'd1);
      chk($sformatf("mmio to c%0d we", c), 32'(mmio_we_out), 32'd1);
      chk($sformatf("mmio to c%0d wdata", c), mmio_wdata_out, 32'h00000055);
    end
    @(negedge clock);
    chk_resp("mmio timeout", v);

    // Repeat, with reset asserted mid-wait: request drops, no response ever.
    @(posedge clock); #1;
    drive(v);
    @(posedge clock); #1;
    idle_inputs();
    repeat (3) @(negedge clock);
    chk("rstwait req before", 32'(mmio_req_out), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstwait req", 32'(mmio_req_out), 32'd0);
    chk("rstwait resp_valid", 32'(resp_valid_out), 32'd0);
    chk("rstwait we", 32'(mmio_we_out), 32'd0);
    chk("rstwait wdata", mmio_wdata_out, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (resp_valid_out || mmio_req_out) hits++;
    end
    chk("rstwait no response", 32'(hits), 32'd0);
    chk("rstwait ready", 32'(ready_out), 32'd1);

    // RAM survives reset.
    v = '{32'h7fff0ffc, 1'b0, 2'b11, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0};
    single("ram after reset", v);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
